shift_result_buffer: RTL

Downstream companion to the pipelined 32-bit barrel shifter (`shift`). It tracks which shifter pipeline slots carry valid operations and captures each result from the shifter's `O` bus exactly `LAT` cycles after issue. Captured results go into a small in-order FIFO with a valid/ready output. Issue flow control is credit-based, so a result leaving the shifter always has a buffer slot and is never dropped.

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_result_buffer_if.sv | 38 +++
 rtl/shift_result_fifo.sv | 68 ++++++
 rtl/shift_result_buffer.sv | 69 ++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the pipelined barrel shifter and its result buffer.
package shift_pkg;

  localparam int WIDTH        = 32;
  localparam int SHIFT_LAT    = 5;
  localparam int RESULT_DEPTH = 8;
  localparam int SHAMT_W      = 5;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/shift_result_buffer_if.sv
// Issue handshake, shifter result bus and buffered output stream of the
// shift result buffer, grouped so both ends share one definition.
interface shift_result_buffer_if #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int DEPTH = shift_pkg::RESULT_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] sh_o;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output issue_valid,
    input  issue_ready,
    output sh_o,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  count
  );

  modport slave (
    input  issue_valid,
    output issue_ready,
    input  sh_o,
    output out_data,
    output out_valid,
    input  out_ready,
    output count
  );

endinterface

// File: rtl/shift_result_fifo.sv
// First-word-fall-through FIFO holding captured shifter results in order.
// Storage is not reset; only the pointers and occupancy are.
module shift_result_fifo #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int DEPTH = shift_pkg::RESULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != '0);
  assign pop     = pop_i && valid_o;
  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem[wr_ptr_q] <= push_data_i;
  end

  // Upstream credit accounting must make a write into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset && push_i) assert (count_q != CW'(DEPTH));
  end

endmodule

// File: rtl/shift_result_buffer.sv
// Tracks which shifter pipeline slots hold real operations, captures each
// result off the shifter bus LAT cycles after issue, and buffers it. Issue is
// only granted when a buffer slot is guaranteed for the eventual result.
module shift_result_buffer #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int LAT   = shift_pkg::SHIFT_LAT,
  parameter int DEPTH = shift_pkg::RESULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_result_buffer_if.slave  bus
);

  localparam int IW = $clog2(LAT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LAT-1:0] vld_q, vld_d;
  logic [IW-1:0]  inf_q, inf_d;
  logic [CW-1:0]  fifoCount;
  logic [31:0]    creditsUsed;
  logic           fire;
  logic           push;
  logic           pop;

  assign fire = bus.issue_valid && bus.issue_ready;
  assign push = vld_q[LAT-1];
  assign pop  = bus.out_valid && bus.out_ready;

  // Credits consider only registered state; a same-cycle pop is not counted.
  always_comb begin
    creditsUsed     = 32'(fifoCount) + 32'(inf_q);
    bus.issue_ready = !reset && (creditsUsed < 32'(DEPTH));
  end

  // Advance the in-flight tracker and keep a running count of its set bits.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = fire;
    inf_d    = inf_q + IW'(fire) - IW'(vld_q[LAT-1]);
  end

  // Tracker registers; reset discards everything still in the shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      inf_q <= '0;
    end else begin
      vld_q <= vld_d;
      inf_q <= inf_d;
    end
  end

  shift_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.sh_o),
    .pop_i       (pop),
    .data_o      (bus.out_data),
    .valid_o     (bus.out_valid),
    .count_o     (fifoCount)
  );

  assign bus.count = fifoCount;

endmodule
